imm_packer: RTL and testbench
=============================

Name: imm_packer

Overview:
- Sequential instruction packer. It is the inverse of the core's immediate sign extender.
- Accepts a stream of {instruction template, 32-bit immediate, ImmSrc} items and scatters each immediate into the RISC-V I/S/B/J bit positions.
- Range-checks the immediate and writes the packed word into instruction memory at consecutive addresses.
- Used as the program loader and self-check assembler that feeds the single-cycle core's instruction memory.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address; capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new load at base_addr; honoured only in IDLE or DONE.
- base_addr  in  ADDR_W  first write address.
- in_valid  in  1  input item valid.
- in_ready  out  1  packer can accept an item.
- in_ImmSrc  in  2  format: 00 I, 01 S, 10 B, 11 J.
- in_imm  in  32  immediate value, byte offset for B/J.
- in_template  in  32  instruction word; its immediate bit positions are ignored.
- in_last  in  1  marks the final item of the program.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  packed instruction.
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse coincident with the final write.
- full  out  1  sticky; load stopped at the top address.
- word_count  out  ADDR_W+1  words written in the current load.
- err_range  out  1  sticky; at least one immediate was unrepresentable.
- err_addr  out  ADDR_W  address of the first out-of-range word.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset: state=IDLE. All outputs 0, including word_count, err_range, err_addr and full. Any pending write is dropped. Reset mid-load aborts the load with no further mem_we.
- FSM states: IDLE, LOAD, DONE.
  - IDLE/DONE + start: go to LOAD. wr_addr=base_addr; clear word_count, err_range, err_addr, full.
  - start in LOAD is ignored.
  - LOAD: in_ready=1. Accept occurs when in_valid && in_ready.
  - Accept with in_last=1, or accept at wr_addr=2^ADDR_W-1, goes to DONE. In the top-address case full is set.
  - DONE: in_ready=0; hold until start or rst.
- Pipeline:
  - One register stage. An item accepted in cycle N produces mem_we=1, mem_addr=wr_addr, mem_wdata=packed word in cycle N+1.
  - wr_addr and word_count increment on each write.
  - Back-to-back accepts give one write per cycle.
  - No backpressure from memory.
- done pulses in the cycle of the final write, whether the load ended by last or by full.
- Packing:
  - Non-immediate bits are copied from in_template.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Range rules (the word is still written, using truncated bits):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - On a violation, err_range is set in the write cycle.
  - err_addr latches only on the first violation of the load.
- Wrap-around: the address never wraps within a load. full terminates the load instead.
- Simultaneous events: rst beats everything. start in DONE in the same cycle as in_valid: start is taken, and the item is not accepted because in_ready=0 that cycle.

Optional Feature:
- IMM_PACKER_RANGE_CHECK_EN defined: the range rules above are active.
- Not defined: the range-check logic is absent, err_range and err_addr are tied 0, and packing is unchanged.

Test Plan:
- I-type: base=0x10, template 0x00000093, imm 0xFFFFFFFF, ImmSrc 00, last=1 -> next cycle mem_we=1, addr 0x10, wdata 0xFFF00093; done=1; word_count=1; err_range=0.
- S then B back-to-back, base 0:
  - item 1: template 0x0020A023, imm 8, ImmSrc 01 -> addr 0, wdata 0x0020A423.
  - item 2: template 0x00000063, imm 0xFFFFFFFC, ImmSrc 10, last=1 -> addr 1, wdata 0xFE000EE3.
  - Writes on consecutive cycles; done with the second write.
- J-type: template 0x000000EF, imm 0x800, ImmSrc 11 -> wdata 0x001000EF, no error.
- Range error (macro defined), base 5:
  - item at addr 5: ImmSrc 00, imm 0x800 -> word 0x80000093 written; err_range=1; err_addr=5.
  - item at addr 6: ImmSrc 10, imm 5 -> err_addr stays 5.
- Full, ADDR_W=2, base=2: after two accepts without last -> in_ready=0, full=1, done on the write to addr 3.
- Reset mid-load: rst asserted the cycle after an accept -> no mem_we; all outputs 0. start then reloads normally.

Source files
------------

// File: rtl/imm_packer.sv
// Sequential RISC-V immediate packer: scatters immediates into I/S/B/J fields and writes packed words to instruction memory.
// Optional IMM_PACKER_RANGE_CHECK_EN enables immediate range checking (err_range / err_addr).
module imm_packer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_ImmSrc,
    input  logic [31:0]       in_imm,
    input  logic [31:0]       in_template,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   word_count,
    output logic              err_range,
    output logic [ADDR_W-1:0] err_addr
);

    // state | meaning
    // IDLE  | after reset, waiting for start
    // LOAD  | accepting items, one write per accept
    // DONE  | load finished by last or full, waiting for start
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] TOP_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_addr;
    logic              accept;
    logic              at_top;
    logic              load_start;
    logic [31:0]       packed_word;

    assign in_ready   = (state == ST_LOAD);
    assign busy       = (state == ST_LOAD);
    assign accept     = in_valid && in_ready;
    assign at_top     = (wr_addr == TOP_ADDR);
    assign load_start = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_comb begin
        packed_word = in_template;
        case (in_ImmSrc)
            2'b00: begin
                packed_word[31:20] = in_imm[11:0];
            end
            2'b01: begin
                packed_word[31:25] = in_imm[11:5];
                packed_word[11:7]  = in_imm[4:0];
            end
            2'b10: begin
                packed_word[31]    = in_imm[12];
                packed_word[30:25] = in_imm[10:5];
                packed_word[11:8]  = in_imm[4:1];
                packed_word[7]     = in_imm[11];
            end
            default: begin
                packed_word[31]    = in_imm[20];
                packed_word[30:21] = in_imm[10:1];
                packed_word[20]    = in_imm[11];
                packed_word[19:12] = in_imm[19:12];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_addr    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            full       <= 1'b0;
            word_count <= '0;
        end else begin
            mem_we <= accept;
            done   <= accept && (in_last || at_top);
            if (accept) begin
                mem_addr   <= wr_addr;
                mem_wdata  <= packed_word;
                word_count <= word_count + CNT_ONE;
                // the address saturates at the top; the load ends there instead of wrapping
                if (!at_top)
                    wr_addr <= wr_addr + ADDR_ONE;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        wr_addr    <= base_addr;
                        word_count <= '0;
                        full       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept && (in_last || at_top))
                        state <= ST_DONE;
                    if (accept && at_top)
                        full <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IMM_PACKER_RANGE_CHECK_EN
    logic imm_ok;
    logic range_viol;

    always_comb begin
        imm_ok = 1'b1;
        case (in_ImmSrc)
            2'b00, 2'b01: imm_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
            2'b10:        imm_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
            default:      imm_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
        endcase
    end

    assign range_viol = accept && !imm_ok;

    // flags become visible together with the offending write
    always_ff @(posedge clk) begin
        if (rst) begin
            err_range <= 1'b0;
            err_addr  <= '0;
        end else if (load_start) begin
            err_range <= 1'b0;
            err_addr  <= '0;
        end else if (range_viol) begin
            err_range <= 1'b1;
            if (!err_range)
                err_addr <= wr_addr;
        end
    end
`else
    assign err_range = 1'b0;
    assign err_addr  = '0;
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Directed self-checking bench for imm_packer (8-bit address instance plus a 2-bit instance for the full case).
module tb_imm_packer;

`ifdef IMM_PACKER_RANGE_CHECK_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ImmSrc;
    logic [31:0] in_imm;
    logic [31:0] in_template;
    logic        in_last;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        full;
    logic [8:0]  word_count;
    logic        err_range;
    logic [7:0]  err_addr;

    logic        s_start;
    logic [1:0]  s_base_addr;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [1:0]  s_in_ImmSrc;
    logic [31:0] s_in_imm;
    logic [31:0] s_in_template;
    logic        s_in_last;
    logic        s_mem_we;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic        s_busy;
    logic        s_done;
    logic        s_full;
    logic [2:0]  s_word_count;
    logic        s_err_range;
    logic [1:0]  s_err_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_packer #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_ImmSrc(in_ImmSrc),
        .in_imm(in_imm), .in_template(in_template), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .full(full), .word_count(word_count),
        .err_range(err_range), .err_addr(err_addr)
    );

    imm_packer #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .base_addr(s_base_addr),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ImmSrc(s_in_ImmSrc),
        .in_imm(s_in_imm), .in_template(s_in_template), .in_last(s_in_last),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .busy(s_busy), .done(s_done), .full(s_full), .word_count(s_word_count),
        .err_range(s_err_range), .err_addr(s_err_addr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_item(input logic [1:0] src, input logic [31:0] imm,
                            input logic [31:0] tmpl, input logic last);
        in_valid    = 1'b1;
        in_ImmSrc   = src;
        in_imm      = imm;
        in_template = tmpl;
        in_last     = last;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        start = 1'b0; base_addr = '0; in_valid = 1'b0; in_ImmSrc = '0;
        in_imm = '0; in_template = '0; in_last = 1'b0;
        s_start = 1'b0; s_base_addr = '0; s_in_valid = 1'b0; s_in_ImmSrc = '0;
        s_in_imm = '0; s_in_template = '0; s_in_last = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if ({in_ready, busy, done, full} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {in_ready, busy, done, full}); end
        checks++; if (word_count !== 9'd0) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
        checks++; if ({err_range, err_addr} !== 9'd0) begin failures++; $display("FAIL reset_err got=%h exp=0", {err_range, err_addr}); end
    endtask

    task automatic test_i_type;
        start = 1'b1; base_addr = 8'h10;
        tick;
        start = 1'b0;
        checks++; if ({busy, in_ready} !== 2'b11) begin failures++; $display("FAIL i_load_state got=%b exp=11", {busy, in_ready}); end
        set_item(2'b00, 32'hFFFF_FFFF, 32'h0000_0093, 1'b1);
        tick;
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL i_mem_we got=%b exp=1", mem_we); end
        checks++; if (mem_addr !== 8'h10) begin failures++; $display("FAIL i_mem_addr got=%h exp=10", mem_addr); end
        checks++; if (mem_wdata !== 32'hFFF0_0093) begin failures++; $display("FAIL i_wdata got=%h exp=fff00093", mem_wdata); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL i_done got=%b exp=1", done); end
        checks++; if (word_count !== 9'd1) begin failures++; $display("FAIL i_word_count got=%0d exp=1", word_count); end
        checks++; if (err_range !== 1'b0) begin failures++; $display("FAIL i_err_range got=%b exp=0", err_range); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL i_done_ready got=%b exp=0", in_ready); end
        tick;
        checks++; if ({mem_we, done} !== 2'b00) begin failures++; $display("FAIL i_after got=%b exp=00", {mem_we, done}); end
    endtask

    task automatic test_back_to_back;
        start = 1'b1; base_addr = 8'h00;
        tick;
        start = 1'b0;
        set_item(2'b01, 32'h0000_0008, 32'h0020_A023, 1'b0);
        tick;
        set_item(2'b10, 32'hFFFF_FFFC, 32'h0000_0063, 1'b1);
        checks++; if ({mem_we, mem_addr} !== {1'b1, 8'h00}) begin failures++; $display("FAIL b2b_w1_addr got=%b/%h exp=1/00", mem_we, mem_addr); end
        checks++; if (mem_wdata !== 32'h0020_A423) begin failures++; $display("FAIL b2b_s_wdata got=%h exp=0020a423", mem_wdata); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_w1_done got=%b exp=0", done); end
        tick;
        in_valid = 1'b0;
        checks++; if ({mem_we, mem_addr} !== {1'b1, 8'h01}) begin failures++; $display("FAIL b2b_w2_addr got=%b/%h exp=1/01", mem_we, mem_addr); end
        checks++; if (mem_wdata !== 32'hFE00_0EE3) begin failures++; $display("FAIL b2b_b_wdata got=%h exp=fe000ee3", mem_wdata); end
        checks++; if ({done, word_count} !== {1'b1, 9'd2}) begin failures++; $display("FAIL b2b_w2_done_cnt got=%b/%0d exp=1/2", done, word_count); end
        tick;
    endtask

    task automatic test_start_in_done_and_j;
        // in DONE: start and in_valid together; start is taken, item is not
        start = 1'b1; base_addr = 8'h40;
        set_item(2'b11, 32'h0000_0800, 32'h0000_00EF, 1'b1);
        tick;
        start = 1'b0;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL done_start_no_accept got=%b exp=0", mem_we); end
        checks++; if ({busy, word_count} !== {1'b1, 9'd0}) begin failures++; $display("FAIL done_start_load got=%b/%0d exp=1/0", busy, word_count); end
        tick;
        in_valid = 1'b0;
        checks++; if ({mem_we, mem_addr} !== {1'b1, 8'h40}) begin failures++; $display("FAIL j_addr got=%b/%h exp=1/40", mem_we, mem_addr); end
        checks++; if (mem_wdata !== 32'h0010_00EF) begin failures++; $display("FAIL j_wdata got=%h exp=001000ef", mem_wdata); end
        checks++; if (err_range !== 1'b0) begin failures++; $display("FAIL j_err_range got=%b exp=0", err_range); end
        tick;
    endtask

    task automatic test_range;
        logic [7:0] exp_addr;
        exp_addr = RC_EN ? 8'h05 : 8'h00;
        start = 1'b1; base_addr = 8'h05;
        tick;
        start = 1'b0;
        set_item(2'b00, 32'h0000_0800, 32'h0000_0093, 1'b0);
        tick;
        set_item(2'b10, 32'h0000_0005, 32'h0000_0063, 1'b1);
        checks++; if ({mem_we, mem_addr} !== {1'b1, 8'h05}) begin failures++; $display("FAIL rng_w1_addr got=%b/%h exp=1/05", mem_we, mem_addr); end
        checks++; if (mem_wdata !== 32'h8000_0093) begin failures++; $display("FAIL rng_w1_wdata got=%h exp=80000093", mem_wdata); end
        checks++; if (err_range !== RC_EN) begin failures++; $display("FAIL rng_w1_err got=%b exp=%b", err_range, RC_EN); end
        checks++; if (err_addr !== exp_addr) begin failures++; $display("FAIL rng_w1_err_addr got=%h exp=%h", err_addr, exp_addr); end
        tick;
        in_valid = 1'b0;
        checks++; if ({mem_addr, mem_wdata} !== {8'h06, 32'h0000_0263}) begin failures++; $display("FAIL rng_w2_word got=%h/%h exp=06/00000263", mem_addr, mem_wdata); end
        checks++; if ({err_range, err_addr} !== {RC_EN, exp_addr}) begin failures++; $display("FAIL rng_w2_err_hold got=%b/%h exp=%b/%h", err_range, err_addr, RC_EN, exp_addr); end
        tick;
        start = 1'b1; base_addr = 8'h00;
        tick;
        start = 1'b0;
        checks++; if ({err_range, err_addr} !== 9'd0) begin failures++; $display("FAIL rng_start_clear got=%b/%h exp=0/00", err_range, err_addr); end
        set_item(2'b00, 32'h0000_0001, 32'h0000_0013, 1'b1);
        tick;
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_full;
        s_start = 1'b1; s_base_addr = 2'd2;
        tick;
        s_start = 1'b0;
        s_in_valid = 1'b1; s_in_ImmSrc = 2'b00; s_in_imm = 32'h1;
        s_in_template = 32'h0000_0013; s_in_last = 1'b0;
        tick;
        checks++; if ({s_mem_we, s_mem_addr, s_full, s_done, s_in_ready} !== {1'b1, 2'd2, 3'b001}) begin failures++; $display("FAIL full_w1 got=%b/%0d/%b%b%b exp=1/2/001", s_mem_we, s_mem_addr, s_full, s_done, s_in_ready); end
        checks++; if (s_mem_wdata !== 32'h0010_0013) begin failures++; $display("FAIL full_w1_wdata got=%h exp=00100013", s_mem_wdata); end
        tick;
        s_in_valid = 1'b0;
        checks++; if ({s_mem_we, s_mem_addr} !== {1'b1, 2'd3}) begin failures++; $display("FAIL full_w2_addr got=%b/%0d exp=1/3", s_mem_we, s_mem_addr); end
        checks++; if ({s_full, s_done, s_in_ready} !== 3'b110) begin failures++; $display("FAIL full_w2_flags got=%b exp=110", {s_full, s_done, s_in_ready}); end
        checks++; if (s_word_count !== 3'd2) begin failures++; $display("FAIL full_word_count got=%0d exp=2", s_word_count); end
        s_in_valid = 1'b1;
        tick;
        s_in_valid = 1'b0;
        checks++; if ({s_mem_we, s_full, s_done} !== 3'b010) begin failures++; $display("FAIL full_sticky got=%b exp=010", {s_mem_we, s_full, s_done}); end
    endtask

    task automatic test_reset_midload;
        start = 1'b1; base_addr = 8'h20;
        tick;
        start = 1'b0;
        set_item(2'b00, 32'h0000_0003, 32'h0000_0013, 1'b0);
        tick;
        rst = 1'b1;
        tick;
        checks++; if ({mem_we, busy, in_ready, done, full} !== 5'b00000) begin failures++; $display("FAIL rstmid_flags got=%b exp=00000", {mem_we, busy, in_ready, done, full}); end
        checks++; if ({mem_addr, mem_wdata, word_count} !== '0) begin failures++; $display("FAIL rstmid_data got=%h/%h/%0d exp=0/0/0", mem_addr, mem_wdata, word_count); end
        tick;
        rst = 1'b0;
        tick;
        in_valid = 1'b0;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rstmid_no_write got=%b exp=0", mem_we); end
        start = 1'b1; base_addr = 8'h30;
        tick;
        start = 1'b0;
        set_item(2'b00, 32'h0000_0003, 32'h0000_0013, 1'b1);
        tick;
        in_valid = 1'b0;
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h30, 32'h0030_0013}) begin failures++; $display("FAIL rstmid_reload got=%b/%h/%h exp=1/30/00300013", mem_we, mem_addr, mem_wdata); end
        checks++; if ({done, word_count} !== {1'b1, 9'd1}) begin failures++; $display("FAIL rstmid_reload_done got=%b/%0d exp=1/1", done, word_count); end
        tick;
    endtask

    initial begin
        test_reset;
        test_i_type;
        test_back_to_back;
        test_start_in_done_and_j;
        test_range;
        test_full;
        test_reset_midload;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
